// File: rtl/scc_pkg.sv
// Shared types and constants for the register-file bank: default sizes,
// the CPSR flag layout and the write-data source select encoding.
package scc_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 8;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } cpsr_t;

    localparam logic WR_SEL_ALU = 1'b0;
    localparam logic WR_SEL_ID  = 1'b1;

endpackage

// File: rtl/reg_file_sb.sv
// Pending-write scoreboard: one bit per GPR, set on multi-cycle issue,
// cleared by the completing write, with per-port busy lookup.
module reg_file_sb #(
    parameter int NUM_REGS     = 8,
    parameter int NUM_RD_PORTS = 2,
    parameter int ADDR_W       = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sb_set,
    input  logic [ADDR_W-1:0]              sb_addr,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0]        rd_busy
);

    logic [NUM_REGS-1:0] pend;

    // A new issue to the same register supersedes the completion landing this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_set && (sb_addr == ADDR_W'(i)))
                    pend[i] <= 1'b1;
                else if (wr_en && (wr_addr == ADDR_W'(i)))
                    pend[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++)
            rd_busy[p] = pend[rd_addr[p*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/reg_file_bank.sv
// GPR bank with pending scoreboard and CPSR flags, between decode and execute.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_bank
    import scc_pkg::*;
#(
    parameter  int DATA_W       = DATA_W_DEF,
    parameter  int NUM_REGS     = NUM_REGS_DEF,
    parameter  int NUM_RD_PORTS = 2,
    localparam int ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_W-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]        rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data_alu,
    input  logic [DATA_W-1:0]              wr_data_id,
    input  logic                           wr_data_sel,
    input  logic                           sb_set,
    input  logic [ADDR_W-1:0]              sb_addr,
    input  logic                           cpsr_wr,
    input  logic [3:0]                     cpsr_wr_data,
    output logic [3:0]                     cpsr
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] wr_data;
    cpsr_t             cpsr_q;

    assign wr_data = (wr_data_sel == WR_SEL_ID) ? wr_data_id : wr_data_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cpsr_q <= '0;
        else if (cpsr_wr)
            cpsr_q <= cpsr_t'(cpsr_wr_data);
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]))
                rd_data[p*DATA_W +: DATA_W] = wr_data;
`endif
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign cpsr = cpsr_wr ? cpsr_wr_data : cpsr_q;
`else
    assign cpsr = cpsr_q;
`endif

    reg_file_sb #(
        .NUM_REGS     (NUM_REGS),
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .ADDR_W       (ADDR_W)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy)
    );

endmodule
